// File: rtl/pulp_clock_gate_ctrl.sv
// Enable sequencer for a pulp_clock_gating cell: idle-driven gating with drain and wake settling.
// Optional gated-cycle statistics counter enabled by defining PULP_CLK_GATE_STATS_EN.
module pulp_clock_gate_ctrl #(
  parameter int unsigned IDLE_CYCLES  = 16,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter int unsigned WAKE_CYCLES  = 4,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        idle_i,
  input  logic        wake_i,
  input  logic        sw_req_i,
  input  logic        test_en_i,
`ifdef PULP_CLK_GATE_STATS_EN
  input  logic        stat_clr_i,
  output logic [31:0] gated_cycles_o,
`endif
  output logic        en_o,
  output logic        clk_ready_o,
  output logic        gated_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GATED = 2'd2,
    ST_WAKE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e           state_r;
  state_e           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             busy_s;
  logic             en_r;
  logic             ready_r;
  logic             gated_r;
  logic [1:0]       state_out_r;

  // Saturating increment: the counter holds at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == CNT_MAX) begin
      sat_inc = v;
    end else begin
      sat_inc = v + CNT_ONE;
    end
  endfunction

  // Next-state and counter logic for the RUN/DRAIN/GATED/WAKE sequence
  always_comb begin
    busy_s      = wake_i | sw_req_i | ~idle_i;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (busy_s) begin
          cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r >= IDLE_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_DRAIN;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      ST_DRAIN: begin
        // Work arriving during drain cancels gating while the clock is still running
        if (busy_s) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_RUN;
        end else if (cnt_r >= DRAIN_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_GATED;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      ST_GATED: begin
        cnt_nxt_s = CNT_ZERO;
        if (busy_s) begin
          state_nxt_s = ST_WAKE;
        end else begin
          state_nxt_s = ST_GATED;
        end
      end
      ST_WAKE: begin
        if (cnt_r >= WAKE_LAST) begin
          cnt_nxt_s   = CNT_ZERO;
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = sat_inc(cnt_r);
        end
      end
      default: begin
        cnt_nxt_s   = CNT_ZERO;
        state_nxt_s = ST_WAKE;
      end
    endcase
  end

  // State, counter and registered outputs decoded from the next state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_WAKE;
      cnt_r       <= CNT_ZERO;
      en_r        <= 1'b1;
      ready_r     <= 1'b0;
      gated_r     <= 1'b0;
      state_out_r <= 2'd3;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      en_r        <= (state_nxt_s != ST_GATED);
      ready_r     <= (state_nxt_s == ST_RUN);
      gated_r     <= (state_nxt_s == ST_GATED);
      state_out_r <= state_nxt_s;
    end
  end

  // Test mode only overrides the enable pin; the FSM keeps its own view
  assign en_o        = en_r | test_en_i;
  assign clk_ready_o = ready_r;
  assign gated_o     = gated_r;
  assign state_o     = state_out_r;

`ifdef PULP_CLK_GATE_STATS_EN
  logic [31:0] gated_cycles_r;

  // Saturating count of cycles spent in GATED; clear wins over increment
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gated_cycles_r <= 32'd0;
    end else if (stat_clr_i) begin
      gated_cycles_r <= 32'd0;
    end else if ((state_r == ST_GATED) && (gated_cycles_r != 32'hFFFF_FFFF)) begin
      gated_cycles_r <= gated_cycles_r + 32'd1;
    end else begin
      gated_cycles_r <= gated_cycles_r;
    end
  end

  assign gated_cycles_o = gated_cycles_r;
`endif

endmodule
